// File: rtl/oram_posmap_unit.sv
// oram_posmap_unit: block-to-leaf position map with lazy leaf assignment from a Galois LFSR.
module oram_posmap_unit #(
  parameter int          D         = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_block,
  input  logic         req_remap,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [D-1:0] rsp_block,
  output logic [D-2:0] rsp_old_pos,
  output logic [D-2:0] rsp_new_pos,
  output logic         rsp_was_empty
);
  localparam int L = D - 1;
  localparam int N = 1 << D;
  typedef enum logic [1:0] {IDLE, LOOKUP, ASSIGN, RESP} state_t;
  state_t         r_state, w_next;
  logic [N-1:0]   r_valid;
  logic [L-1:0]   r_pos [N];
  logic [15:0]    r_lfsr, w_lfsr_step;
  logic [L-1:0]   w_draw, w_new, r_old, r_new;
  logic [D-1:0]   r_block;
  logic           r_remap, r_empty;
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
  assign w_draw      = r_lfsr[L-1:0];
  assign w_new       = r_remap ? w_draw : r_old;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? LOOKUP : IDLE;
      LOOKUP:  w_next = ASSIGN;
      ASSIGN:  w_next = RESP;
      default: w_next = rsp_ready ? IDLE : RESP;
    endcase
  end
  assign req_ready     = (r_state == IDLE);
  assign rsp_valid     = (r_state == RESP);
  assign rsp_block     = r_block;
  assign rsp_old_pos   = r_old;
  assign rsp_new_pos   = r_new;
  assign rsp_was_empty = r_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_lfsr  <= LFSR_SEED;
      r_block <= '0;
      r_remap <= 1'b0;
      r_old   <= '0;
      r_new   <= '0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_block <= req_block;
        r_remap <= req_remap;
      end
      if (r_state == LOOKUP) begin
        r_empty <= !r_valid[r_block];
        r_old   <= r_valid[r_block] ? r_pos[r_block] : w_draw;
        if (!r_valid[r_block]) r_lfsr <= w_lfsr_step;
      end
      if (r_state == ASSIGN) begin
        r_new            <= w_new;
        r_valid[r_block] <= 1'b1;
        if (r_remap) r_lfsr <= w_lfsr_step;
      end
    end
  end
  // Leaf storage needs no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ASSIGN) r_pos[r_block] <= w_new;
  end
endmodule

// File: tb/tb_oram_posmap_unit.sv
// tb_oram_posmap_unit: randomized accesses checked against an array-based position-map model.
module tb_oram_posmap_unit;
  localparam int D = 6;
  localparam int N = 1 << D;
  logic         clk = 0, rst = 1;
  logic         req_valid = 0, req_ready, req_remap = 0;
  logic [D-1:0] req_block = '0;
  logic         rsp_valid, rsp_ready = 0, rsp_was_empty;
  logic [D-1:0] rsp_block;
  logic [D-2:0] rsp_old_pos, rsp_new_pos;
  int checks = 0, failures = 0;
  logic [15:0] m_lfsr;
  bit          m_valid [N];
  int          m_pos [N];

  oram_posmap_unit #(.D(D), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block), .req_remap(req_remap),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_block(rsp_block),
    .rsp_old_pos(rsp_old_pos), .rsp_new_pos(rsp_new_pos), .rsp_was_empty(rsp_was_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_draw(output int v);
    v = m_lfsr % 32;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(posedge clk); @(posedge clk);
    #1 rst = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_block", rsp_block, 0);
    chk("rst_old_new_empty", {rsp_old_pos, rsp_new_pos, rsp_was_empty}, 0);
  endtask

  task automatic access(input int b, input bit remap, input int hold, output int e_old, output int e_new);
    int n, e_empty;
    e_empty = !m_valid[b];
    if (e_empty) model_draw(e_old); else e_old = m_pos[b];
    if (remap) model_draw(e_new); else e_new = e_old;
    m_valid[b] = 1;
    m_pos[b] = e_new;
    @(negedge clk);
    req_valid = 1; req_block = D'(b); req_remap = remap;
    @(posedge clk);
    #1 req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1 n++;
    end
    chk("latency", n, 3);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_block", rsp_block, b);
      chk("rsp_old_pos", rsp_old_pos, e_old);
      chk("rsp_new_pos", rsp_new_pos, e_new);
      chk("rsp_was_empty", rsp_was_empty, e_empty);
      if (i == hold) break;
      chk("req_ready_busy", req_ready, 0);
      req_valid = (i == 0 && hold >= 2);
      req_block = D'($urandom_range(N - 1));
      @(posedge clk); #1;
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_idle", req_ready, 1);
  endtask

  initial begin
    int o, nw, n;
    do_reset();
    access(5, 1, 0, o, nw);
    chk("plan1_old", o, 1);
    chk("plan1_new", nw, 16);
    access(5, 0, 0, o, nw);
    chk("plan2_new", nw, 16);
    access(5, 1, 5, o, nw);
    chk("plan3_new", nw, 24);
    access(9, 1, 0, o, nw);
    chk("plan3_next_draw", o, 28);
    // Reset lands on the ASSIGN edge: no write, LFSR reseeded.
    do_reset();
    @(negedge clk);
    req_valid = 1; req_block = 5; req_remap = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 if (rsp_valid) n++;
    end
    chk("no_rsp_after_rst", n, 0);
    m_lfsr = 16'hACE1;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    access(5, 1, 0, o, nw);
    chk("rst_assign_old", o, 1);
    chk("rst_assign_new", nw, 16);
    do_reset();
    access(0, 0, 0, o, nw);
    chk("b0_old", o, 1);
    access(N - 1, 0, 0, o, nw);
    chk("b63_old", o, 16);
    access(0, 0, 1, o, nw);
    chk("b0_again_old", o, 1);
    for (int k = 0; k < 80; k++)
      access($urandom_range(N - 1), 1'($urandom_range(1)), $urandom_range(3), o, nw);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
